// File: rtl/led_chase_ctrl_pkg.sv
// Shared definitions for the LED chase sequencer: state encoding, bar
// geometry, mode/direction encodings and the one-hot position decoder.
package led_pkg;

    localparam int LED_COUNT = 16;
    localparam int POS_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic MODE_WRAP   = 1'b0;
    localparam logic MODE_BOUNCE = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [POS_W-1:0] POS_FIRST = POS_W'(0);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(LED_COUNT - 1);
    localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);

    // One-hot image of a bar position.
    function automatic logic [LED_COUNT-1:0] onehot_f(input logic [POS_W-1:0] p);
        logic [LED_COUNT-1:0] v;
        v = {{(LED_COUNT-1){1'b0}}, 1'b1};
        return v << p;
    endfunction

endpackage

// File: rtl/led_chase_ctrl_if.sv
// Control/status bundle between the switch/button front end (master) and
// the LED chase sequencer (slave).
interface led_chase_if;
    import led_pkg::*;

    logic                 start;
    logic                 hold;
    logic                 mode;
    logic                 dir;
    logic [1:0]           speed;
    logic [LED_COUNT-1:0] led;
    logic [POS_W-1:0]     pos;
    logic                 step;

    modport master (
        output start, hold, mode, dir, speed,
        input  led, pos, step
    );

    modport slave (
        input  start, hold, mode, dir, speed,
        output led, pos, step
    );

endinterface

// File: rtl/led_chase_ctrl_tick_gen.sv
// Step prescaler: counts enabled cycles and flags the terminal count of a
// period of TICK_DIV >> speed clocks. The terminal test is ">=" so that a
// speed increase mid-count fires on the next edge instead of overflowing.
module led_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] speed,
    output logic       tick
);

    localparam int          CNT_W      = $clog2(TICK_DIV);
    localparam logic [31:0] TICK_DIV_U = 32'(TICK_DIV);

    logic [CNT_W-1:0] count_r;
    logic [31:0]      limit_s;
    logic [31:0]      term_s;
    logic             at_term_s;

    // Period limit for the selected speed and terminal-count detect.
    always_comb begin
        limit_s   = TICK_DIV_U >> speed;
        term_s    = limit_s - 32'd1;
        at_term_s = (32'(count_r) >= term_s);
        tick      = en & at_term_s;
    end

    // Prescaler count: cleared on request, frozen when not enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en) begin
            if (at_term_s) begin
                count_r <= {CNT_W{1'b0}};
            end else begin
                count_r <= count_r + CNT_W'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/led_chase_ctrl.sv
// LED chase sequencer for the 16-LED bar: IDLE/RUN/HOLD control, lit
// position and direction registers, and registered LED decode.
// Optional build macro LED_CHASE_TRAIL_EN adds a previous-position register
// so the bar shows a two-LED trail (current | previous position).
module led_chase_ctrl
    import led_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    led_chase_if.slave  bus
);

    state_e               state_r;
    state_e               state_nxt_s;
    logic [POS_W-1:0]     pos_r;
    logic [POS_W-1:0]     pos_nxt_s;
    logic                 dir_r;
    logic                 dir_nxt_s;
    logic                 step_r;
    logic                 step_nxt_s;
    logic [LED_COUNT-1:0] led_r;
    logic [LED_COUNT-1:0] led_nxt_s;
    logic                 tick_s;
    logic                 tick_en_s;
    logic                 tick_clr_s;
`ifdef LED_CHASE_TRAIL_EN
    logic [POS_W-1:0]     prev_r;
    logic [POS_W-1:0]     prev_nxt_s;
`endif

    // Prescaler runs only while active and not held; dropping start (or
    // sitting in IDLE) restarts it from zero so a restart gets a full period.
    always_comb begin
        tick_en_s  = bus.start & ~bus.hold & (state_r != IDLE);
        tick_clr_s = (state_r == IDLE) | ~bus.start;
    end

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr_s),
        .en    (tick_en_s),
        .speed (bus.speed),
        .tick  (tick_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: start low wins over everything, then hold.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (!bus.start) begin
                    state_nxt_s = IDLE;
                end else if (bus.hold) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            HOLD: begin
                if (!bus.start) begin
                    state_nxt_s = IDLE;
                end else if (!bus.hold) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Next position/direction: cleared in IDLE, seeded on RUN entry, and
    // advanced on a prescaler tick in wrap or bounce fashion.
    always_comb begin
        pos_nxt_s  = pos_r;
        dir_nxt_s  = dir_r;
        step_nxt_s = 1'b0;
`ifdef LED_CHASE_TRAIL_EN
        prev_nxt_s = prev_r;
`endif
        if (state_nxt_s == IDLE) begin
            pos_nxt_s = POS_FIRST;
`ifdef LED_CHASE_TRAIL_EN
            prev_nxt_s = POS_FIRST;
`endif
        end else if (state_r == IDLE) begin
            pos_nxt_s = POS_FIRST;
            dir_nxt_s = bus.dir;
`ifdef LED_CHASE_TRAIL_EN
            prev_nxt_s = POS_FIRST;
`endif
        end else if (tick_s) begin
            step_nxt_s = 1'b1;
`ifdef LED_CHASE_TRAIL_EN
            prev_nxt_s = pos_r;
`endif
            if (bus.mode == MODE_WRAP) begin
                // Wrap: the direction switch is live at every step.
                dir_nxt_s = bus.dir;
                if (bus.dir == DIR_UP) begin
                    pos_nxt_s = pos_r + POS_ONE;
                end else begin
                    pos_nxt_s = pos_r - POS_ONE;
                end
            end else begin
                // Bounce: turn around at the ends without repeating them.
                if (dir_r == DIR_UP) begin
                    if (pos_r == POS_LAST) begin
                        pos_nxt_s = POS_LAST - POS_ONE;
                        dir_nxt_s = DIR_DOWN;
                    end else begin
                        pos_nxt_s = pos_r + POS_ONE;
                    end
                end else begin
                    if (pos_r == POS_FIRST) begin
                        pos_nxt_s = POS_ONE;
                        dir_nxt_s = DIR_UP;
                    end else begin
                        pos_nxt_s = pos_r - POS_ONE;
                    end
                end
            end
        end else begin
            pos_nxt_s = pos_r;
        end
    end

    // LED image of the next position (dark in IDLE).
    always_comb begin
        led_nxt_s = {LED_COUNT{1'b0}};
        if (state_nxt_s != IDLE) begin
`ifdef LED_CHASE_TRAIL_EN
            led_nxt_s = onehot_f(pos_nxt_s) | onehot_f(prev_nxt_s);
`else
            led_nxt_s = onehot_f(pos_nxt_s);
`endif
        end else begin
            led_nxt_s = {LED_COUNT{1'b0}};
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_r  <= POS_FIRST;
            dir_r  <= DIR_UP;
            step_r <= 1'b0;
            led_r  <= {LED_COUNT{1'b0}};
`ifdef LED_CHASE_TRAIL_EN
            prev_r <= POS_FIRST;
`endif
        end else begin
            pos_r  <= pos_nxt_s;
            dir_r  <= dir_nxt_s;
            step_r <= step_nxt_s;
            led_r  <= led_nxt_s;
`ifdef LED_CHASE_TRAIL_EN
            prev_r <= prev_nxt_s;
`endif
        end
    end

    assign bus.led  = led_r;
    assign bus.pos  = pos_r;
    assign bus.step = step_r;

endmodule

// File: tb/tb_led_chase_ctrl.sv
// Self-checking bench for led_chase_ctrl with TICK_DIV = 8.
module tb_led_chase_ctrl;
    import led_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    led_chase_if bus();

    led_chase_ctrl #(.TICK_DIV(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       start;
        logic       hold;
        logic       mode;
        logic       dir;
        logic [1:0] speed;
        logic       active;
        logic [3:0] pos;
        logic       step;
    } vec_t;

    vec_t vecs [17];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    function automatic logic [15:0] exp_led_f(input logic active, input logic [3:0] p,
                                              input logic [3:0] pv);
        logic [15:0] v;
        v = 16'd0;
        if (active) begin
            v = 16'd1 << p;
`ifdef LED_CHASE_TRAIL_EN
            v = v | (16'd1 << pv);
`endif
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic s, input logic h, input logic m, input logic d,
                          input logic [1:0] sp);
        bus.start = s;
        bus.hold  = h;
        bus.mode  = m;
        bus.dir   = d;
        bus.speed = sp;
    endtask

    task automatic wait_step(input int budget, output int cnt);
        cnt = 0;
        do begin
            clk1();
            cnt++;
        end while (bus.step !== 1'b1 && cnt < budget);
    endtask

    task automatic go_idle();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        clk1();
        clk1();
    endtask

    initial begin
        logic       prev_active;
        logic [3:0] last_pos;
        logic [3:0] m_prev;
        logic [3:0] ep;
        int         cnt;

        // start, hold, mode, dir, speed | active, pos, step
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 4'd0,  1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 4'd1,  1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 4'd2,  1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 4'd1,  1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 4'd0,  1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 4'd15, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 4'd0,  1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 4'd0,  1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 4'd0,  1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 4'd0,  1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 4'd0,  1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 4'd1,  1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 4'd2,  1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 4'd1,  1'b1};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 4'd0,  1'b1};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 4'd1,  1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 4'd0,  1'b0};

        // Reset state.
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        #12;
        check("reset_led", 32'(bus.led), 32'h0);
        check("reset_pos", 32'(bus.pos), 32'h0);
        check("reset_step", 32'(bus.step), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        clk1();
        clk1();
        check("idle_led", 32'(bus.led), 32'h0);

        // Table-driven vectors at speed 3 (one step per cycle).
        prev_active = 1'b0;
        last_pos    = 4'd0;
        m_prev      = 4'd0;
        for (int i = 0; i < 17; i++) begin
            set_in(vecs[i].start, vecs[i].hold, vecs[i].mode, vecs[i].dir, vecs[i].speed);
            clk1();
            if (vecs[i].active && !prev_active) begin
                m_prev = vecs[i].pos;
            end else if (vecs[i].step) begin
                m_prev = last_pos;
            end
            check($sformatf("vec%0d_led", i), 32'(bus.led),
                  32'(exp_led_f(vecs[i].active, vecs[i].pos, m_prev)));
            check($sformatf("vec%0d_pos", i), 32'(bus.pos), 32'(vecs[i].pos));
            check($sformatf("vec%0d_step", i), 32'(bus.step), 32'(vecs[i].step));
            prev_active = vecs[i].active;
            last_pos    = vecs[i].pos;
        end

        // Wrap up at speed 0: a step every 8 cycles, full circle back to 0.
        go_idle();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        clk1();
        check("wrap_entry_led", 32'(bus.led), 32'h0001);
        check("wrap_entry_pos", 32'(bus.pos), 32'h0);
        for (int k = 1; k <= 16; k++) begin
            wait_step(20, cnt);
            ep = 4'(k);
            check($sformatf("wrap%0d_period", k), 32'(cnt), 32'd8);
            check($sformatf("wrap%0d_pos", k), 32'(bus.pos), 32'(ep));
            check($sformatf("wrap%0d_led", k), 32'(bus.led), 32'(exp_led_f(1'b1, ep, 4'(k - 1))));
        end

        // Bounce from 0 going down: 0,1..15,14..0,1.
        go_idle();
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 2'd3);
        clk1();
        check("bounce_entry_pos", 32'(bus.pos), 32'h0);
        last_pos = 4'd0;
        for (int k = 1; k <= 31; k++) begin
            clk1();
            if (k <= 15) ep = 4'(k);
            else if (k <= 30) ep = 4'(30 - k);
            else ep = 4'(k - 30);
            check($sformatf("bounce%0d_pos", k), 32'(bus.pos), 32'(ep));
            check($sformatf("bounce%0d_led", k), 32'(bus.led), 32'(exp_led_f(1'b1, ep, last_pos)));
            last_pos = ep;
        end

        // Hold 3 cycles after a step for 20 cycles; resume needs 5 more.
        go_idle();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        clk1();
        wait_step(20, cnt);
        check("hold_first_period", 32'(cnt), 32'd8);
        repeat (3) clk1();
        bus.hold = 1'b1;
        for (int k = 0; k < 20; k++) begin
            clk1();
            check($sformatf("hold%0d_step", k), 32'(bus.step), 32'h0);
            check($sformatf("hold%0d_led", k), 32'(bus.led), 32'(exp_led_f(1'b1, 4'd1, 4'd0)));
        end
        bus.hold = 1'b0;
        wait_step(20, cnt);
        check("hold_resume_period", 32'(cnt), 32'd5);
        check("hold_resume_pos", 32'(bus.pos), 32'd2);

        // Speed change 0 -> 2 with prescaler at 5: step next edge, then every 2.
        go_idle();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        clk1();
        wait_step(20, cnt);
        repeat (5) clk1();
        bus.speed = 2'd2;
        wait_step(20, cnt);
        check("speed_first", 32'(cnt), 32'd1);
        wait_step(20, cnt);
        check("speed_second", 32'(cnt), 32'd2);
        wait_step(20, cnt);
        check("speed_third", 32'(cnt), 32'd2);
        check("speed_pos", 32'(bus.pos), 32'd4);

        // Stop priority over hold and a pending terminal count.
        go_idle();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        clk1();
        wait_step(20, cnt);
        repeat (7) clk1();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        clk1();
        check("stop_led", 32'(bus.led), 32'h0);
        check("stop_pos", 32'(bus.pos), 32'h0);
        check("stop_step", 32'(bus.step), 32'h0);
        clk1();
        check("stop_step_after", 32'(bus.step), 32'h0);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        clk1();
        check("restart_led", 32'(bus.led), 32'h0001);
        wait_step(20, cnt);
        check("restart_period", 32'(cnt), 32'd8);
`ifdef LED_CHASE_TRAIL_EN
        check("restart_step_led", 32'(bus.led), 32'h0003);
`else
        check("restart_step_led", 32'(bus.led), 32'h0002);
`endif

        // Asynchronous reset in the middle of a step cycle.
        wait_step(20, cnt);
        check("prereset_step", 32'(bus.step), 32'h1);
        #3;
        reset = 1'b0;
        #1;
        check("areset_led", 32'(bus.led), 32'h0);
        check("areset_pos", 32'(bus.pos), 32'h0);
        check("areset_step", 32'(bus.step), 32'h0);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) clk1();
        check("post_reset_led", 32'(bus.led), 32'h0);
        check("post_reset_pos", 32'(bus.pos), 32'h0);
        check("post_reset_step", 32'(bus.step), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
